page_fixup_seq: RTL and testbench
=================================

Name: page_fixup_seq

Overview:
- Consumer side of the ALU free-carry path in the control logic.
- Latches the carry out of a low-byte address add (indexed absolute/indirect, or relative branch) and decides whether a page-boundary fix-up cycle is needed.
- If so, sequences that cycle by driving the ALU carry-in and the inc/dec select for the high byte.
- Sits between the ALU carry output and the instruction-decode cycle generator. The decoder uses pageCross to insert or skip the extra cycle.

Parameters:
FORCE_FIX_EN, 1, 1 = forceFix input honoured (writes/RMW always take the fix-up cycle); 0 = forceFix ignored

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
enableFFs  input  1  global clock-enable; 0 freezes all state (stall)
abort  input  1  synchronous instruction abort; returns to IDLE
lowAdd  input  1  decoder strobe: this cycle is the low-byte add
ALUcarry  input  1  ALU carry out, sampled when lowAdd accepted
isBranch  input  1  qualifies lowAdd: 1 = relative branch, 0 = indexed address
offsetNeg  input  1  branch offset sign (bit 7), sampled with lowAdd
forceFix  input  1  instruction always takes fix-up (store/RMW), sampled with lowAdd
freeCarry  output  1  latched carry from last accepted lowAdd
pageCross  output  1  valid in CHECK: 1 = fix-up cycle follows
fixInc  output  1  FIXUP cycle, high byte +1
fixDec  output  1  FIXUP cycle, high byte -1
aluCarryIn  output  1  ALU carry-in for the current cycle
fixDone  output  1  one-cycle pulse at the end of a fix-up or skip
protocolErr  output  1  sticky: lowAdd seen outside IDLE
state  output  2  IDLE=0, CHECK=1, FIXUP=2 (3 unused, decodes to IDLE)

Behaviour:
- Async reset (nrst=0):
  - state=IDLE; freeCarry, mode, neg and force registers =0.
  - protocolErr=0; all combinational outputs 0.
- Update rule: all registers update only on posedge clk with enableFFs=1, except abort and reset.
  - enableFFs=0: every register holds, outputs remain stable for that cycle.
- abort=1 at a clock edge, regardless of enableFFs:
  - state<=IDLE, freeCarry<=0.
  - protocolErr unchanged; no fixDone.
  - abort has priority over all other inputs.
- IDLE:
  - lowAdd=1 latches freeCarry<=ALUcarry, mode<=isBranch, neg<=offsetNeg, force<=forceFix&FORCE_FIX_EN; state<=CHECK.
  - Otherwise stay in IDLE; freeCarry holds.
- CHECK: needFix is computed from latched values only.
  - Indexed: needFix = freeCarry | force.
  - Branch: needFix = freeCarry ^ neg. Carry with positive offset gives inc; no carry with negative offset gives dec. force is ignored for branches.
  - pageCross=needFix.
  - needFix=1: state<=FIXUP.
  - needFix=0: fixDone=1 this cycle, state<=IDLE.
- FIXUP (exactly one enabled cycle):
  - Branch with neg=1: fixDec=1, aluCarryIn=0 (decoder adds 0xFF).
  - Any other case: fixInc=1, aluCarryIn=1 (add 0x00 with carry).
  - Indexed force with no carry still fixInc=1, aluCarryIn=freeCarry, so the high byte is unchanged. Only freeCarry drives aluCarryIn in this case.
  - fixDone=1; state<=IDLE.
- aluCarryIn=0 in IDLE and CHECK.
- Latency: lowAdd edge → pageCross valid the next cycle → fix-up the cycle after that.
  - Total 2 cycles with fix, 1 without (fixDone in CHECK).
- lowAdd=1 in CHECK or FIXUP:
  - Ignored, no relatch.
  - protocolErr<=1 if enableFFs=1; cleared only by nrst.
- enableFFs=0 while in CHECK/FIXUP:
  - Outputs are held and fixDone stays high across stalled cycles.
  - The decoder must also stall, so it counts fixDone once per enabled edge.
- Reset mid-sequence: immediate IDLE, no fixDone.
- fixInc and fixDec are never both 1.
- Outputs are combinational from registered state only; there is no input→output combinational path.

Test Plan:
- Indexed, no cross: lowAdd=1, isBranch=0, ALUcarry=0, forceFix=0 → next cycle state=1, pageCross=0, fixDone=1; then IDLE, fixInc never asserted.
- Indexed cross: ALUcarry=1 → CHECK pageCross=1; next cycle FIXUP fixInc=1, aluCarryIn=1, fixDone=1; then IDLE, freeCarry=1 retained.
- Branch backward no cross vs cross:
  - offsetNeg=1, ALUcarry=1 → pageCross=0.
  - offsetNeg=1, ALUcarry=0 → FIXUP with fixDec=1, aluCarryIn=0.
- Store forced fix: forceFix=1, ALUcarry=0, FORCE_FIX_EN=1 → FIXUP with aluCarryIn=0.
  - Repeat with FORCE_FIX_EN=0 → pageCross=0.
- Stall and abort:
  - Hold enableFFs=0 for 3 cycles in CHECK → state/pageCross frozen, resumes correctly.
  - abort=1 in FIXUP with enableFFs=0 → IDLE, freeCarry=0, no fixDone.
- Protocol/reset:
  - lowAdd pulse in CHECK → no relatch, protocolErr=1 sticky.
  - nrst low mid-FIXUP → all outputs 0 asynchronously, protocolErr=0.

Source files
------------

// File: rtl/page_fixup_seq_if.sv
// Handshake bundle between the instruction-decode cycle generator and the
// page fix-up sequencer. The master is the decoder side and the slave is the sequencer.
interface page_fixup_seq_if;
    logic       enableFFs;
    logic       abort;
    logic       lowAdd;
    logic       ALUcarry;
    logic       isBranch;
    logic       offsetNeg;
    logic       forceFix;
    logic       freeCarry;
    logic       pageCross;
    logic       fixInc;
    logic       fixDec;
    logic       aluCarryIn;
    logic       fixDone;
    logic       protocolErr;
    logic [1:0] state;

    modport master (
        output enableFFs, abort, lowAdd, ALUcarry, isBranch, offsetNeg, forceFix,
        input  freeCarry, pageCross, fixInc, fixDec, aluCarryIn, fixDone, protocolErr, state
    );

    modport slave (
        input  enableFFs, abort, lowAdd, ALUcarry, isBranch, offsetNeg, forceFix,
        output freeCarry, pageCross, fixInc, fixDec, aluCarryIn, fixDone, protocolErr, state
    );
endinterface

// File: rtl/page_fixup_seq.sv
// Page-boundary fix-up sequencer: latches the low-byte add carry, decides whether the
// high byte needs a correction cycle, and drives the ALU carry-in and inc/dec for that cycle.
module page_fixup_seq #(
    parameter bit FORCE_FIX_EN = 1'b1
) (
    input logic             clk,
    input logic             nrst,
    page_fixup_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FIXUP = 2'd2
    } stateT;

    stateT stateQ, stateD;
    logic  freeCarryQ, freeCarryD;
    logic  modeQ, modeD;
    logic  negQ, negD;
    logic  forceQ, forceD;
    logic  protocolErrQ, protocolErrD;

    logic  needFix;
    logic  branchBack;
    logic  pageCross;
    logic  fixInc;
    logic  fixDec;
    logic  aluCarryIn;
    logic  fixDone;

    // The decision uses only latched operands, so the outputs never see the inputs.
    always_comb begin
        branchBack = modeQ & negQ;
        needFix    = modeQ ? (freeCarryQ ^ negQ) : (freeCarryQ | forceQ);
    end

    always_comb begin
        stateD       = stateQ;
        freeCarryD   = freeCarryQ;
        modeD        = modeQ;
        negD         = negQ;
        forceD       = forceQ;
        protocolErrD = protocolErrQ;
        pageCross    = 1'b0;
        fixInc       = 1'b0;
        fixDec       = 1'b0;
        aluCarryIn   = 1'b0;
        fixDone      = 1'b0;

        case (stateQ)
            CHECK: begin
                pageCross = needFix;
                if (needFix) begin
                    stateD = FIXUP;
                end else begin
                    fixDone = 1'b1;
                    stateD  = IDLE;
                end
                if (bus.lowAdd) begin
                    protocolErrD = 1'b1;
                end
            end

            FIXUP: begin
                // Backward branch adds 0xFF; everything else adds 0x00 plus the latched
                // carry, which leaves the high byte unchanged on a forced store with no carry.
                fixDec     = branchBack;
                fixInc     = ~branchBack;
                aluCarryIn = branchBack ? 1'b0 : (modeQ | freeCarryQ);
                fixDone    = 1'b1;
                stateD     = IDLE;
                if (bus.lowAdd) begin
                    protocolErrD = 1'b1;
                end
            end

            default: begin
                if (bus.lowAdd) begin
                    freeCarryD = bus.ALUcarry;
                    modeD      = bus.isBranch;
                    negD       = bus.offsetNeg;
                    forceD     = bus.forceFix & FORCE_FIX_EN;
                    stateD     = CHECK;
                end
            end
        endcase
    end

    // Abort wins over the stall so a frozen decoder can still drop the instruction.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stateQ       <= IDLE;
            freeCarryQ   <= 1'b0;
            modeQ        <= 1'b0;
            negQ         <= 1'b0;
            forceQ       <= 1'b0;
            protocolErrQ <= 1'b0;
        end else if (bus.abort) begin
            stateQ     <= IDLE;
            freeCarryQ <= 1'b0;
        end else if (bus.enableFFs) begin
            stateQ       <= stateD;
            freeCarryQ   <= freeCarryD;
            modeQ        <= modeD;
            negQ         <= negD;
            forceQ       <= forceD;
            protocolErrQ <= protocolErrD;
        end
    end

    assign bus.state       = stateQ;
    assign bus.freeCarry   = freeCarryQ;
    assign bus.protocolErr = protocolErrQ;
    assign bus.pageCross   = pageCross;
    assign bus.fixInc      = fixInc;
    assign bus.fixDec      = fixDec;
    assign bus.aluCarryIn  = aluCarryIn;
    assign bus.fixDone     = fixDone;

    incDecExclusive: assert property (@(posedge clk) disable iff (!nrst) !(fixInc && fixDec));

    fixupOneCycle: assert property (@(posedge clk) disable iff (!nrst)
        (stateQ == FIXUP && bus.enableFFs) |=> (stateQ == IDLE));

endmodule

// File: tb/tb_page_fixup_seq.sv
// Bench for page_fixup_seq: table vectors, corner sequences and random traffic checked
// against a queue-of-expected-cycles model, on a forced-fix and a non-forced instance.
module tb_page_fixup_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst;
    logic enableFFs, abort, lowAdd, ALUcarry, isBranch, offsetNeg, forceFix;

    page_fixup_seq_if busF();
    page_fixup_seq_if busN();

    assign busF.enableFFs = enableFFs;
    assign busF.abort     = abort;
    assign busF.lowAdd    = lowAdd;
    assign busF.ALUcarry  = ALUcarry;
    assign busF.isBranch  = isBranch;
    assign busF.offsetNeg = offsetNeg;
    assign busF.forceFix  = forceFix;
    assign busN.enableFFs = enableFFs;
    assign busN.abort     = abort;
    assign busN.lowAdd    = lowAdd;
    assign busN.ALUcarry  = ALUcarry;
    assign busN.isBranch  = isBranch;
    assign busN.offsetNeg = offsetNeg;
    assign busN.forceFix  = forceFix;

    page_fixup_seq #(.FORCE_FIX_EN(1'b1)) dutF (.clk(clk), .nrst(nrst), .bus(busF.slave));
    page_fixup_seq #(.FORCE_FIX_EN(1'b0)) dutN (.clk(clk), .nrst(nrst), .bus(busN.slave));

    // Observation layout: [8:7] state, 6 pageCross, 5 fixInc, 4 fixDec, 3 aluCarryIn,
    // 2 fixDone, 1 freeCarry, 0 protocolErr
    logic [8:0] obs [2];
    assign obs[0] = {busF.state, busF.pageCross, busF.fixInc, busF.fixDec, busF.aluCarryIn,
                     busF.fixDone, busF.freeCarry, busF.protocolErr};
    assign obs[1] = {busN.state, busN.pageCross, busN.fixInc, busN.fixDec, busN.aluCarryIn,
                     busN.fixDone, busN.freeCarry, busN.protocolErr};

    typedef struct {
        logic [1:0] st;
        logic       pc, inc, dec, cin, done;
    } cyc_t;

    // Each accepted lowAdd schedules the outputs of its remaining cycles; empty means idle.
    cyc_t expQ [2][$];
    logic mFc  [2];
    logic mErr [2];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] expVec(input int i);
        cyc_t r;
        if (expQ[i].size() == 0) return {7'd0, mFc[i], mErr[i]};
        r = expQ[i][0];
        return {r.st, r.pc, r.inc, r.dec, r.cin, r.done, mFc[i], mErr[i]};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            expQ[i].delete();
            mFc[i]  = 1'b0;
            mErr[i] = 1'b0;
        end
    endtask

    task automatic modelEdge();
        for (int i = 0; i < 2; i++) begin
            logic fe, need, back;
            cyc_t r;
            if (abort) begin
                expQ[i].delete();
                mFc[i] = 1'b0;
            end else if (enableFFs) begin
                if (expQ[i].size() != 0) begin
                    if (lowAdd) mErr[i] = 1'b1;
                    void'(expQ[i].pop_front());
                end else if (lowAdd) begin
                    fe     = forceFix & (i == 0);
                    need   = isBranch ? (ALUcarry ^ offsetNeg) : (ALUcarry | fe);
                    back   = isBranch & offsetNeg;
                    mFc[i] = ALUcarry;
                    r.st = 2'd1; r.pc = need; r.inc = 1'b0; r.dec = 1'b0; r.cin = 1'b0;
                    r.done = ~need;
                    expQ[i].push_back(r);
                    if (need) begin
                        r.st = 2'd2; r.pc = 1'b0; r.inc = ~back; r.dec = back;
                        r.cin = back ? 1'b0 : (isBranch ? 1'b1 : ALUcarry);
                        r.done = 1'b1;
                        expQ[i].push_back(r);
                    end
                end
            end
        end
    endtask

    task automatic step(input string tag);
        modelEdge();
        @(posedge clk);
        @(negedge clk);
        check({tag, "/F"}, obs[0], expVec(0));
        check({tag, "/N"}, obs[1], expVec(1));
    endtask

    task automatic idleInputs();
        enableFFs = 1'b1; abort = 1'b0; lowAdd = 1'b0;
        ALUcarry = 1'b0; isBranch = 1'b0; offsetNeg = 1'b0; forceFix = 1'b0;
    endtask

    task automatic issue(input logic c, input logic b, input logic n, input logic f);
        lowAdd = 1'b1; ALUcarry = c; isBranch = b; offsetNeg = n; forceFix = f;
    endtask

    typedef struct {
        logic c, b, n, f;
        logic pcF, pcN, inc, dec, cin;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // indexed, no cross
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // indexed, cross
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // back branch, same page
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // back branch, cross
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // fwd branch, cross
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // fwd branch, same page
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // forced store, no carry
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // forced store, carry
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // force ignored on branch

        nrst = 1'b0;
        idleInputs();
        modelReset();
        @(negedge clk);
        check("resetF", obs[0], 9'd0);
        check("resetN", obs[1], 9'd0);
        nrst = 1'b1;
        step("idle");

        for (int k = 0; k < 9; k++) begin
            issue(tbl[k].c, tbl[k].b, tbl[k].n, tbl[k].f);
            step("vecLatch");
            // Scramble the live inputs so only the latched copies can matter.
            idleInputs();
            ALUcarry = ~tbl[k].c; offsetNeg = ~tbl[k].n; isBranch = ~tbl[k].b; forceFix = 1'b1;
            check("vecPageCrossF", {8'd0, obs[0][6]}, {8'd0, tbl[k].pcF});
            check("vecPageCrossN", {8'd0, obs[1][6]}, {8'd0, tbl[k].pcN});
            step("vecFix");
            if (tbl[k].pcF)
                check("vecFixF", {6'd0, obs[0][5:3]}, {6'd0, tbl[k].inc, tbl[k].dec, tbl[k].cin});
            if (tbl[k].pcN)
                check("vecFixN", {6'd0, obs[1][5:3]}, {6'd0, tbl[k].inc, tbl[k].dec, tbl[k].cin});
            idleInputs();
            step("vecIdle");
            check("vecCarryKept", {7'd0, obs[0][8:7]}, 9'd0);
            check("vecFreeCarry", {8'd0, obs[0][1]}, {8'd0, tbl[k].c});
        end

        // Stall for three cycles in CHECK, then resume into FIXUP.
        issue(1'b1, 1'b0, 1'b0, 1'b0);
        step("stallLatch");
        idleInputs();
        enableFFs = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step("stall");
            check("stallFrozen", {6'd0, obs[0][8:6]}, 9'b0_0000_0011);
        end
        enableFFs = 1'b1;
        step("resume");
        check("resumeFixup", {6'd0, obs[0][8:7], obs[0][5]}, 9'b0_0000_0101);
        step("resumeIdle");

        // Abort while stalled in FIXUP.
        issue(1'b1, 1'b0, 1'b0, 1'b0);
        step("abortLatch");
        idleInputs();
        step("abortFix");
        enableFFs = 1'b0;
        abort = 1'b1;
        step("abort");
        check("abortIdle", {5'd0, obs[0][8:7], obs[0][2], obs[0][1]}, 9'd0);
        idleInputs();
        step("abortAfter");

        // lowAdd in CHECK: ignored and flagged, flag sticks.
        issue(1'b1, 1'b0, 1'b0, 1'b0);
        step("protoLatch");
        issue(1'b0, 1'b1, 1'b1, 1'b0);
        step("protoCheck");
        check("protoNoRelatch", {7'd0, obs[0][8:7]}, 9'd2);
        check("protoErrSet", {8'd0, obs[0][0]}, 9'd1);
        idleInputs();
        step("protoA");
        step("protoB");
        check("protoErrSticky", {8'd0, obs[0][0]}, 9'd1);

        // Asynchronous reset in the middle of FIXUP.
        issue(1'b1, 1'b0, 1'b0, 1'b0);
        step("rstLatch");
        idleInputs();
        step("rstFix");
        #2 nrst = 1'b0;
        #1;
        check("asyncResetF", obs[0], 9'd0);
        check("asyncResetN", obs[1], 9'd0);
        modelReset();
        @(negedge clk);
        nrst = 1'b1;
        step("postReset");

        for (int r = 0; r < 3000; r++) begin
            enableFFs = ($urandom_range(0, 7) != 0);
            abort     = ($urandom_range(0, 19) == 0);
            lowAdd    = ($urandom_range(0, 2) == 0);
            ALUcarry  = $urandom_range(0, 1);
            isBranch  = $urandom_range(0, 1);
            offsetNeg = $urandom_range(0, 1);
            forceFix  = $urandom_range(0, 1);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
